// File: rtl/pixel_sched_pkg.sv
// Shared types for the pixel sampler stage: scheduler state, sample tag layout,
// and the default frame geometry reused by the sampler and framebuffer blocks.
package pixel_sched_pkg;

  localparam int DEFAULT_H_RES = 800;
  localparam int DEFAULT_V_RES = 600;
  localparam int COORD_W       = 10;
  // Sample index field is sized for the largest supported SPP (256).
  localparam int TAG_IDX_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } sched_state_e;

  typedef struct packed {
    logic                 valid;
    logic [COORD_W-1:0]   x;
    logic [COORD_W-1:0]   y;
    logic [TAG_IDX_W-1:0] s;
    logic                 last;
  } pixel_tag_t;

endpackage

// File: rtl/pixel_tag_pipe.sv
// Shift register of sample tags whose depth matches the sampler latency, so the
// tag leaving the last stage lines up with the sampler's registered result.
module pixel_tag_pipe
  import pixel_sched_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  pixel_tag_t issue_tag,
  output pixel_tag_t final_tag
);

  pixel_tag_t stage [DEPTH];

  // NOTE: the whole tag is reset, not only the valid bits, so every out_* field
  // reads zero while reset is asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (en) begin
      stage[0] <= issue_tag;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign final_tag = stage[DEPTH-1];

endmodule

// File: rtl/pixel_sample_scheduler.sv
// Frame sequencer for the pixel sampler: raster-order sample issue plus a tag
// pipeline aligned to the sampler. Define PIXEL_SCHED_CONTINUOUS_EN for back-to-back frames.
module pixel_sample_scheduler
  import pixel_sched_pkg::*;
#(
  parameter int H_RES           = DEFAULT_H_RES,
  parameter int V_RES           = DEFAULT_V_RES,
  parameter int SPP             = 4,
  parameter int SAMPLER_LATENCY = 3,
  localparam int SW             = (SPP > 1) ? $clog2(SPP) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               frame_done,
  output logic [COORD_W-1:0] smp_pixel_x,
  output logic [COORD_W-1:0] smp_pixel_y,
  output logic               smp_stall,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COORD_W-1:0] out_pixel_x,
  output logic [COORD_W-1:0] out_pixel_y,
  output logic [SW-1:0]      out_sample_idx,
  output logic               out_last
);

  sched_state_e       state, state_nxt;
  logic [COORD_W-1:0] x_cnt, y_cnt;
  logic [SW-1:0]      s_cnt;
  pixel_tag_t         issue_tag, final_tag;

  logic stall, issue, advance, accept, last_accept;
  logic last_s, last_x, last_y, frame_end;

  assign stall       = final_tag.valid & ~out_ready;
  assign issue       = (state == ST_RUN) & ~stall;
  assign accept      = final_tag.valid & out_ready;
  assign last_accept = accept & final_tag.last;

  assign last_s    = (s_cnt == SW'(SPP - 1));
  assign last_x    = (x_cnt == COORD_W'(H_RES - 1));
  assign last_y    = (y_cnt == COORD_W'(V_RES - 1));
  assign frame_end = last_s & last_x & last_y;

`ifdef PIXEL_SCHED_CONTINUOUS_EN
  assign advance = issue;
`else
  // Single-shot frames keep the counters parked on the final pixel.
  assign advance = issue & ~frame_end;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start) state_nxt = ST_RUN;
`ifdef PIXEL_SCHED_CONTINUOUS_EN
      ST_RUN:   state_nxt = ST_RUN;
`else
      ST_RUN:   if (issue && frame_end) state_nxt = ST_DRAIN;
`endif
      ST_DRAIN: if (last_accept) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Issue counters: sample index fastest, then x, then y.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_cnt <= '0;
      y_cnt <= '0;
      s_cnt <= '0;
    end else if (state == ST_IDLE && start) begin
      x_cnt <= '0;
      y_cnt <= '0;
      s_cnt <= '0;
    end else if (advance) begin
      if (last_s) begin
        s_cnt <= '0;
        if (last_x) begin
          x_cnt <= '0;
          y_cnt <= last_y ? '0 : y_cnt + 1'b1;
        end else begin
          x_cnt <= x_cnt + 1'b1;
        end
      end else begin
        s_cnt <= s_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    issue_tag       = '0;
    issue_tag.valid = (state == ST_RUN);
    issue_tag.x     = x_cnt;
    issue_tag.y     = y_cnt;
    issue_tag.s     = TAG_IDX_W'(s_cnt);
    issue_tag.last  = frame_end;
  end

  pixel_tag_pipe #(
    .DEPTH (SAMPLER_LATENCY)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .en        (~stall),
    .issue_tag (issue_tag),
    .final_tag (final_tag)
  );

  always_comb begin
    busy           = (state != ST_IDLE);
    frame_done     = last_accept;
    smp_pixel_x    = x_cnt;
    smp_pixel_y    = y_cnt;
    smp_stall      = stall;
    out_valid      = final_tag.valid;
    out_pixel_x    = final_tag.x;
    out_pixel_y    = final_tag.y;
    out_sample_idx = final_tag.s[SW-1:0];
    out_last       = final_tag.last;
  end

endmodule
